// File: rtl/inst_prefetch.sv
// Instruction prefetch queue.
// Fetches sequential instruction words from a single-outstanding-request
// memory port into a DEPTH-entry FIFO, hands the head entry to IF/ID, and
// flushes/refetches on a redirect. A response whose request was overtaken by
// a redirect is still waited for (DROP) so the bus stays one-request-deep.
`timescale 1ns/1ps
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        valid_o,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Word-align a fetch address (low two bits forced to zero).
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [31:0]     fetch_pc_r, fetch_pc_nxt_s;
  logic [31:0]     req_addr_r, req_addr_nxt_s;
  logic            req_r, req_nxt_s;
  logic [CW-1:0]   count_r, count_nxt_s, count_after_pop_s;
  logic [PW-1:0]   rd_ptr_r, rd_ptr_nxt_s;
  logic [PW-1:0]   wr_ptr_r, wr_ptr_nxt_s;
  logic [31:0]     addr_mem_r [DEPTH];
  logic [31:0]     inst_mem_r [DEPTH];
  logic            push_s, pop_s;
  logic            valid_r, valid_nxt_s;
  logic [31:0]     inst_r, inst_nxt_s;
  logic [31:0]     pc4_r, pc4_nxt_s;

  // Next-state, queue bookkeeping and head-of-queue output computation.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    push_s         = 1'b0;
    pop_s          = valid_r && !stall_i && !redirect_i;
    count_after_pop_s = count_r - CW'(pop_s);

    case (state_r)
      ST_IDLE: begin
        if (redirect_i) begin
          fetch_pc_nxt_s = align_pc(redirect_pc_i);
          state_nxt_s    = ST_REQ;
        end else if (count_after_pop_s < DEPTH_C) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          // Data arriving with the redirect belongs to the old stream.
          fetch_pc_nxt_s = align_pc(redirect_pc_i);
          state_nxt_s    = mem_ack_i ? ST_REQ : ST_DROP;
        end else if (mem_ack_i) begin
          push_s         = 1'b1;
          fetch_pc_nxt_s = fetch_pc_r + 32'd4;
          state_nxt_s    = ((count_after_pop_s + CW'(1)) < DEPTH_C) ? ST_REQ : ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          fetch_pc_nxt_s = align_pc(redirect_pc_i);
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        state_nxt_s = mem_ack_i ? ST_REQ : ST_DROP;
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        fetch_pc_nxt_s = fetch_pc_r;
      end
    endcase

    if (redirect_i) begin
      count_nxt_s  = {CW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
      wr_ptr_nxt_s = {PW{1'b0}};
    end else begin
      count_nxt_s  = count_after_pop_s + CW'(push_s);
      rd_ptr_nxt_s = rd_ptr_r + PW'(pop_s);
      wr_ptr_nxt_s = wr_ptr_r + PW'(push_s);
    end

    // A new request address is latched only when no request is in flight
    // or the current one completes, so mem_addr_o is stable until its ack.
    if ((state_r == ST_IDLE) || mem_ack_i) begin
      req_addr_nxt_s = fetch_pc_nxt_s;
    end else begin
      req_addr_nxt_s = req_addr_r;
    end
    req_nxt_s = (state_nxt_s != ST_IDLE);

    // Head after this cycle: the word being pushed if the queue drains to
    // empty first, otherwise the stored entry at the next read pointer.
    valid_nxt_s = (count_nxt_s != {CW{1'b0}});
    if (!valid_nxt_s) begin
      inst_nxt_s = 32'h0000_0000;
      pc4_nxt_s  = 32'h0000_0000;
    end else if (count_after_pop_s == {CW{1'b0}}) begin
      inst_nxt_s = mem_data_i;
      pc4_nxt_s  = fetch_pc_r + 32'd4;
    end else begin
      inst_nxt_s = inst_mem_r[rd_ptr_nxt_s];
      pc4_nxt_s  = addr_mem_r[rd_ptr_nxt_s] + 32'd4;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
      req_r      <= 1'b0;
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      valid_r    <= 1'b0;
      inst_r     <= 32'h0000_0000;
      pc4_r      <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      req_addr_r <= req_addr_nxt_s;
      req_r      <= req_nxt_s;
      count_r    <= count_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      valid_r    <= valid_nxt_s;
      inst_r     <= inst_nxt_s;
      pc4_r      <= pc4_nxt_s;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= fetch_pc_r;
      inst_mem_r[wr_ptr_r] <= mem_data_i;
    end
  end

  assign mem_req_o  = req_r;
  assign mem_addr_o = req_addr_r;
  assign valid_o    = valid_r;
  assign inst_o     = inst_r;
  assign pc4_o      = pc4_r;

endmodule

// File: tb/tb_inst_prefetch.sv
// Testbench for inst_prefetch: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] pc4_o;
  logic        valid_o;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .inst_o(inst_o), .pc4_o(pc4_o), .valid_o(valid_o),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of fetched words, one optional pending request,
  // and whether that request's answer is to be thrown away.
  logic [31:0] q_addr[$];
  logic [31:0] q_inst[$];
  logic        m_pend;
  logic        m_drop;
  logic [31:0] m_pend_addr;
  logic [31:0] m_fetch_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_inst.delete();
    m_pend      = 1'b0;
    m_drop      = 1'b0;
    m_pend_addr = RESET_PC;
    m_fetch_pc  = RESET_PC;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                            input logic ak, input logic [31:0] dt);
    logic pop;
    pop = (q_addr.size() != 0) && !st && !rd;
    if (rd) begin
      q_addr.delete();
      q_inst.delete();
      m_fetch_pc = rpc & 32'hFFFF_FFFC;
      if (m_pend && !ak) begin
        m_drop = 1'b1;
      end else begin
        m_pend = 1'b0;
        m_drop = 1'b0;
      end
    end else begin
      if (pop) begin
        void'(q_addr.pop_front());
        void'(q_inst.pop_front());
      end
      if (m_pend && ak) begin
        if (!m_drop) begin
          q_addr.push_back(m_pend_addr);
          q_inst.push_back(dt);
          m_fetch_pc = m_pend_addr + 32'd4;
        end
        m_pend = 1'b0;
        m_drop = 1'b0;
      end
    end
    if (!m_pend && (q_addr.size() < int'(DEPTH))) begin
      m_pend      = 1'b1;
      m_pend_addr = m_fetch_pc;
    end
  endtask

  task automatic check_outputs(input string where);
    logic        ev;
    logic [31:0] ei, ep;
    ev = (q_addr.size() != 0);
    ei = ev ? q_inst[0] : 32'h0;
    ep = ev ? (q_addr[0] + 32'd4) : 32'h0;
    check_eq({where, ".valid"}, {31'b0, valid_o}, {31'b0, ev});
    check_eq({where, ".inst"}, inst_o, ei);
    check_eq({where, ".pc4"}, pc4_o, ep);
    check_eq({where, ".req"}, {31'b0, mem_req_o}, {31'b0, m_pend});
    if (m_pend) check_eq({where, ".addr"}, mem_addr_o, m_pend_addr);
  endtask

  // One clock: drive inputs, model the edge, check 1 ns after it.
  task automatic cycle(input string where, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic ak, input logic [31:0] dt);
    logic a;
    a = ak & m_pend;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc; mem_ack_i = a; mem_data_i = dt;
    @(posedge clk_i);
    model_step(st, rd, rpc, a, dt);
    #1;
    check_outputs(where);
  endtask

  function automatic logic [31:0] pat();
    return m_pend_addr ^ 32'hA5A5_A5A5;
  endfunction

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset");
    check_eq("reset.addr", mem_addr_o, RESET_PC);
    rst_n_i = 1'b1;
    cycle("first", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("first.req", {31'b0, mem_req_o}, 32'd1);
    check_eq("first.addr", mem_addr_o, RESET_PC);

    // Streaming: ack every cycle, no stall
    for (int i = 0; i < 10; i++) cycle("stream", 1'b0, 1'b0, 32'h0, 1'b1, pat());

    // Fill under stall: restart at 0 then hold the consumer
    cycle("fill", 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 32'h0, 1'b1, pat());
    check_eq("full.req", {31'b0, mem_req_o}, 32'd0);
    check_eq("full.head_pc4", pc4_o, 32'h0000_0004);
    for (int i = 0; i < 3; i++) cycle("unstall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("unstall.addr", mem_addr_o, 32'h0000_0010);

    // Redirect while request to 0x8 pending
    cycle("rd8", 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle("rd8", 1'b1, 1'b0, 32'h0, 1'b1, pat());
    check_eq("rd8.pending", mem_addr_o, 32'h0000_0008);
    cycle("rd8", 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    check_eq("rd8.valid", {31'b0, valid_o}, 32'd0);
    check_eq("rd8.hold_addr", mem_addr_o, 32'h0000_0008);
    cycle("rd8", 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check_eq("rd8.valid_after_drop", {31'b0, valid_o}, 32'd0);
    check_eq("rd8.new_addr", mem_addr_o, 32'h0000_0100);

    // Redirect coincident with ack and pop
    for (int i = 0; i < 2; i++) cycle("rdack", 1'b0, 1'b0, 32'h0, 1'b1, pat());
    cycle("rdack", 1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h1234_5678);
    check_eq("rdack.valid", {31'b0, valid_o}, 32'd0);
    check_eq("rdack.addr", mem_addr_o, 32'h0000_0200);

    // Fetch address wrap
    cycle("wrap", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle("wrap", 1'b1, 1'b0, 32'h0, 1'b1, pat());
    check_eq("wrap.pc4_first", pc4_o, 32'h0000_0000);
    cycle("wrap", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("wrap.pc4_second", pc4_o, 32'h0000_0004);

    // Reset pulse mid-request with 3 entries queued
    cycle("rstp", 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle("rstp", 1'b1, 1'b0, 32'h0, 1'b1, pat());
    check_eq("rstp.count3_pc4", pc4_o, 32'h0000_0044);
    mem_ack_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_outputs("rstp.async");
    check_eq("rstp.addr", mem_addr_o, RESET_PC);
    #2;
    rst_n_i = 1'b1;
    cycle("rstp.restart", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("rstp.restart_addr", mem_addr_o, RESET_PC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic st, rd, ak;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 40);
      rd  = ($urandom_range(0, 99) < 5);
      ak  = ($urandom_range(0, 99) < 55);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      cycle("rand", st, rd, rpc, ak, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
